round_tail: RTL and testbench
=============================

# round_tail

Registered ShiftRows → MixColumns → AddRoundKey stage of the pipelined AES encryption datapath. Sits directly downstream of `sub_bytes` and consumes its 128-bit output. Re-aligns the round's sideband (valid, last-round flag, round key) to the `sub_bytes` latency, then delivers one complete round result per cycle to the next round stage or the ciphertext register.

## Interface
- `BLOCK_LENGTH`, default 128: state width in bits; only 128 is supported.
- `SB_LATENCY`, default 1: register latency in cycles of the upstream `sub_bytes`; legal range 0–3.

- `clk` input 1: single clock; all state is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sb_in` input 128: state from `sub_bytes` `OUT`.
- `in_valid` input 1: high in the cycle the corresponding state is presented to `sub_bytes` `IN`.
- `in_last` input 1: final-round flag, sampled with `in_valid`; skips MixColumns.
- `in_round_key` input 128: round key for this block, sampled with `in_valid`.
- `out_state` output 128: round result.
- `out_valid` output 1: `out_state` holds a new result this cycle.
- `out_last` output 1: result is the final-round result (ciphertext).

## Operation
- **Byte order**
  - Byte k = bits [127-8k -: 8].
  - Column-major: byte k sits at row k%4, column k/4.
- **Sideband alignment**
  - `in_valid`, `in_last` and `in_round_key` pass through a delay line `SB_LATENCY` deep.
  - This keeps them aligned with `sb_in`.
  - Every delay stage resets to 0.
- **ShiftRows**
  - sr(r,c) = sb_in(r,(c+r) mod 4).
- **MixColumns** (GF(2^8), poly 0x11B, xtime(b) = {b[6:0],0} ^ (b[7] ? 0x1B : 0)), per column:
  - m0 = 2a0^3a1^a2^a3
  - m1 = a0^2a1^3a2^a3
  - m2 = a0^a1^2a2^3a3
  - m3 = 3a0^a1^a2^2a3
  - Bypassed (m = sr) when the aligned last flag is 1.
- **AddRoundKey**
  - result = m ^ aligned key.
- **Output register**
  - Loads `out_state` and `out_last` only when the aligned valid is 1.
  - Otherwise holds its previous values.
  - `out_valid` is the registered aligned valid; it is 0 in every cycle without a new result.
- **Throughput**
  - One block per cycle, back-to-back, no bubbles.
  - No back-pressure: the downstream must accept every `out_valid` cycle.

## Timing
- Latency: `out_valid` rises exactly `SB_LATENCY`+1 cycles after the `in_valid` cycle.
- Reset:
  - `out_state` = 0, `out_valid` = 0, `out_last` = 0.
  - All delay stages cleared asynchronously on `rst` low.
- Reset mid-operation:
  - All in-flight blocks are discarded; no `out_valid` for them after release.
  - The first valid input after `rst` rises produces output with the normal latency.
- `in_last` and `in_round_key` are ignored in cycles where `in_valid` = 0. They never disturb in-flight blocks.
- Consecutive blocks with differing `in_last` and keys each use their own sideband; there is no cross-contamination.
- The only combinational path is `sb_in` through SR/MC/ARK to the output register. There is no input-to-output combinational path.

## Structure
- Shared package (`aes_pkg`) holds:
  - `xtime` and GF multiply-by-2/3 functions
  - byte-index helpers
  - the 0x1B reduction constant
  - `AES_BLOCK = 128`
- One sub-module, `mix_column`: a combinational 32-bit single-column transform, instantiated 4×.
- ShiftRows and AddRoundKey are pure wiring/XOR in the top.
- The delay line is a generate loop over `SB_LATENCY`.

## Test plan
- **FIPS-197 round 1**
  - Stimulus: `sb_in` = d42711ae_e0bf98f1_b8b45de5_1e415230, key = a0fafe17_88542cb1_23a33939_2a6c7605, `in_last` = 0.
  - Required: `out_state` = a49c7ff2_689f352b_6b5bea43_026a5049, `out_valid` = 1 exactly `SB_LATENCY`+1 cycles later.
- **Last-round ShiftRows only**
  - Stimulus: `sb_in` = 00010203_..._0e0f, key = 0, `in_last` = 1.
  - Required: `out_state` = 00050a0f_04090e03_080d0207_0c01060b, `out_last` = 1.
- **Back-to-back blocks**
  - Stimulus: 8 consecutive `in_valid` cycles with alternating `in_last` and distinct keys.
  - Required: 8 consecutive `out_valid` cycles, each matching a reference model in order.
- **Gaps**
  - Stimulus: valid, idle, valid pattern.
  - Required: `out_valid` reproduces the gap pattern; `out_state` holds the previous result during the idle cycle.
- **Reset mid-flight**
  - Stimulus: assert `rst` low one cycle after `in_valid`.
  - Required: outputs go to 0 immediately (asynchronously); no `out_valid` appears after release.
- **Sideband garbage**
  - Stimulus: random `in_round_key` / `in_last` while `in_valid` = 0, interleaved with valid blocks.
  - Required: valid results are unaffected.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
//  aes_pkg
//  Shared AES constants, GF(2^8) helpers and byte-index helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int         AES_BLOCK = 128;
    localparam logic [7:0] GF_REDUCE = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // State is column-major: byte k lives at row k%4, column k/4.
    function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
        return 4 * col + row;
    endfunction

    function automatic int unsigned byte_msb(input int unsigned k);
        return 127 - 8 * k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column.sv
// ============================================================================
//  mix_column
//  Combinational MixColumns transform of a single 32-bit state column.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out = {
        gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3,
        a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
        a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3),
        gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3)
    };

endmodule

`default_nettype wire

// File: rtl/round_tail.sv
// ============================================================================
//  round_tail
//  Registered ShiftRows -> MixColumns -> AddRoundKey stage with sideband
//  re-alignment to the upstream sub_bytes latency.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module round_tail
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int SB_LATENCY   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] sb_in,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [BLOCK_LENGTH-1:0] in_round_key,
    output logic [BLOCK_LENGTH-1:0] out_state,
    output logic                    out_valid,
    output logic                    out_last
);

    localparam int DEPTH = (SB_LATENCY > 0) ? SB_LATENCY : 1;

    logic                    al_valid;
    logic                    al_last;
    logic [BLOCK_LENGTH-1:0] al_key;

    logic                    dl_valid [0:DEPTH-1];
    logic                    dl_last  [0:DEPTH-1];
    logic [BLOCK_LENGTH-1:0] dl_key   [0:DEPTH-1];

    generate
        if (SB_LATENCY == 0) begin : g_no_delay
            assign al_valid = in_valid;
            assign al_last  = in_last;
            assign al_key   = in_round_key;
        end else begin : g_delay
            for (genvar i = 0; i < SB_LATENCY; i++) begin : g_stage
                if (i == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            dl_valid[i] <= 1'b0;
                            dl_last[i]  <= 1'b0;
                            dl_key[i]   <= '0;
                        end else begin
                            dl_valid[i] <= in_valid;
                            dl_last[i]  <= in_last;
                            dl_key[i]   <= in_round_key;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            dl_valid[i] <= 1'b0;
                            dl_last[i]  <= 1'b0;
                            dl_key[i]   <= '0;
                        end else begin
                            dl_valid[i] <= dl_valid[i-1];
                            dl_last[i]  <= dl_last[i-1];
                            dl_key[i]   <= dl_key[i-1];
                        end
                    end
                end
            end
            assign al_valid = dl_valid[SB_LATENCY-1];
            assign al_last  = dl_last[SB_LATENCY-1];
            assign al_key   = dl_key[SB_LATENCY-1];
        end
    endgenerate

    logic [BLOCK_LENGTH-1:0] sr;
    logic [BLOCK_LENGTH-1:0] mc;
    logic [BLOCK_LENGTH-1:0] ark;

    always_comb begin
        sr = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                sr[byte_msb(byte_idx(r, c)) -: 8] = sb_in[byte_msb(byte_idx(r, (c + r) % 4)) -: 8];
            end
        end
    end

    generate
        for (genvar c = 0; c < 4; c++) begin : g_col
            mix_column u_mix_column (
                .col_in  (sr[BLOCK_LENGTH-1-32*c -: 32]),
                .col_out (mc[BLOCK_LENGTH-1-32*c -: 32])
            );
        end
    endgenerate

    // The final round skips MixColumns.
    assign ark = (al_last ? sr : mc) ^ al_key;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= al_valid;
            if (al_valid) begin
                out_state <= ark;
                out_last  <= al_last;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_round_tail.sv
// ============================================================================
//  tb_round_tail
//  Randomized self-checking bench for round_tail against a matrix-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_round_tail;

    localparam int LAT = 1;
    localparam int N   = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] sb_in = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [127:0] in_round_key = '0;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_last;

    round_tail #(
        .BLOCK_LENGTH (128),
        .SB_LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sb_in        (sb_in),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_round_key (in_round_key),
        .out_state    (out_state),
        .out_valid    (out_valid),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic         tv  [0:N-1];
    logic         tl  [0:N-1];
    logic [127:0] tk  [0:N-1];
    logic [127:0] tsb [0:N-1];

    logic [127:0] exp_state = '0;
    logic         exp_last  = 1'b0;
    logic         exp_valid = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // FIPS-197 round: matrix view of the state, circulant {2,3,1,1} multiply.
    function automatic logic [127:0] ref_round(input logic [127:0] sb, input logic [127:0] key, input logic last);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] m [16];
        logic [7:0] coef [4];
        logic [127:0] res;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        for (int k = 0; k < 16; k++) s[k] = sb[127-8*k -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r + 4*c] = s[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                m[r + 4*c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    m[r + 4*c] ^= gmul(coef[(j - r + 4) % 4], t[j + 4*c]);
            end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = (last ? t[k] : m[k]) ^ key[127-8*k -: 8];
        return res;
    endfunction

    task automatic clear_tables();
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0; tl[i] = $urandom_range(0, 1); tk[i] = rnd128(); tsb[i] = rnd128();
        end
    endtask

    // Entered and left at #1 after a rising edge; drains the pipeline before returning.
    task automatic run_phase(input string name, input int n);
        for (int c = 0; c < n + LAT + 1; c++) begin
            in_valid     = (c < n) ? tv[c] : 1'b0;
            in_last      = (c < n) ? tl[c] : 1'($urandom_range(0, 1));
            in_round_key = (c < n) ? tk[c] : rnd128();
            sb_in        = (c >= LAT && c - LAT < n) ? tsb[c-LAT] : rnd128();
            @(posedge clk); #1;
            if (c >= LAT && c - LAT < n && tv[c-LAT]) begin
                exp_valid = 1'b1;
                exp_state = ref_round(tsb[c-LAT], tk[c-LAT], tl[c-LAT]);
                exp_last  = tl[c-LAT];
            end else begin
                exp_valid = 1'b0;
            end
            check({name, ".out_valid"}, 128'(out_valid), 128'(exp_valid));
            check({name, ".out_state"}, out_state, exp_state);
            check({name, ".out_last"},  128'(out_last), 128'(exp_last));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_state", out_state, '0);
        check("reset.out_valid", 128'(out_valid), 128'(0));
        check("reset.out_last",  128'(out_last), 128'(0));
        rst = 1'b1;

        clear_tables();
        tv[0] = 1'b1; tl[0] = 1'b0;
        tsb[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
        tk[0]  = 128'ha0fafe1788542cb123a339392a6c7605;
        run_phase("fips", 1);
        check("fips.vector", out_state, 128'ha49c7ff2689f352b6b5bea43026a5049);

        clear_tables();
        tv[0] = 1'b1; tl[0] = 1'b1; tk[0] = '0;
        tsb[0] = 128'h000102030405060708090a0b0c0d0e0f;
        run_phase("lastrnd", 1);
        check("lastrnd.vector", out_state, 128'h00050a0f04090e03080d02070c01060b);
        check("lastrnd.flag", 128'(out_last), 128'(1));

        clear_tables();
        for (int i = 0; i < 8; i++) begin
            tv[i] = 1'b1; tl[i] = i[0]; tk[i] = rnd128() ^ 128'(i);
        end
        run_phase("b2b", 8);

        clear_tables();
        tv[0] = 1'b1; tv[2] = 1'b1;
        run_phase("gap", 3);

        clear_tables();
        for (int i = 0; i < 40; i++) tv[i] = 1'($urandom_range(0, 1));
        run_phase("garbage", 40);

        clear_tables();
        in_valid = 1'b1; in_last = 1'b0; in_round_key = rnd128(); sb_in = rnd128();
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rstmid.out_state", out_state, '0);
        check("rstmid.out_valid", 128'(out_valid), 128'(0));
        check("rstmid.out_last",  128'(out_last), 128'(0));
        exp_state = '0; exp_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_phase("rstmid", 4);

        clear_tables();
        for (int i = 0; i < 20; i++) tv[i] = 1'($urandom_range(0, 1));
        tv[0] = 1'b1;
        run_phase("postrst", 20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
